// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: runs word, byte and pointer-indirect accesses against the
// single-port memory, stalling the pipeline until the access retires.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        read,
    input  logic        write,
    input  logic        indirect,
    input  logic [1:0]  mem_byte_sig,
    input  logic [15:0] address,
    input  logic [15:0] store_data,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_wdata,
    output logic        stall,
    output logic        done,
    output logic [15:0] load_data,
    output logic        err
);

    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StPtr, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     load_q, load_d;
    logic            rd_q, rd_d;
    logic            word_q, word_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            hit;
    logic            timeout_hit;
    logic [15:0]     word_addr;
    logic [15:0]     aligned;

    assign hit         = req_valid & (read | write) & (mem_byte_sig != 2'b00);
    // A response in the final wait cycle takes priority over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && !mem_resp && (cnt_q == CntLast);
    assign word_addr   = {addr_q[15:1], 1'b0};
    assign aligned     = word_q    ? mem_rdata :
                         addr_q[0] ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        load_d          = load_q;
        rd_d            = rd_q;
        word_d          = word_q;
        err_d           = err_q;
        cnt_d           = cnt_q;
        mem_address     = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_wdata       = 16'h0000;
        stall           = 1'b0;
        done            = 1'b0;
        load_data       = 16'h0000;
        err             = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall = hit;
                if (hit) begin
                    addr_d  = address;
                    wdata_d = store_data;
                    rd_d    = read;
                    word_d  = indirect | (mem_byte_sig == 2'b11);
                    cnt_d   = '0;
                    load_d  = 16'h0000;
                    err_d   = 1'b0;
                    state_d = indirect ? StPtr : StAccess;
                end
            end
            StPtr: begin
                stall           = 1'b1;
                mem_read        = 1'b1;
                mem_address     = word_addr;
                mem_byte_enable = 2'b11;
                if (mem_resp) begin
                    addr_d  = mem_rdata;
                    cnt_d   = '0;
                    state_d = StAccess;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    load_d  = 16'h0000;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAccess: begin
                stall           = 1'b1;
                mem_read        = rd_q;
                mem_write       = ~rd_q;
                mem_address     = word_addr;
                mem_byte_enable = word_q ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);
                if (!rd_q) begin
                    mem_wdata = word_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]};
                end
                if (mem_resp) begin
                    load_d  = rd_q ? aligned : 16'h0000;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    load_d  = 16'h0000;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                done      = 1'b1;
                load_data = load_q;
                err       = err_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            load_q  <= 16'h0000;
            rd_q    <= 1'b0;
            word_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            word_q  <= word_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed transactions expanded into per-cycle expected
// outputs from the access rules, checked every cycle by a single compare process.
module tb_mem_access_unit;

    localparam int To = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, read, write, indirect;
    logic [1:0]  mem_byte_sig;
    logic [15:0] address, store_data;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic [15:0] mem_address, mem_wdata, load_data;
    logic        mem_read, mem_write, stall, done, err;
    logic [1:0]  mem_byte_enable;

    mem_access_unit #(.TIMEOUT(To)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .read           (read),
        .write          (write),
        .indirect       (indirect),
        .mem_byte_sig   (mem_byte_sig),
        .address        (address),
        .store_data     (store_data),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_wdata      (mem_wdata),
        .stall          (stall),
        .done           (done),
        .load_data      (load_data),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, req, rd, wr, ind, resp;
        logic [1:0]  sig;
        logic [15:0] addr, sd, rdata;
        logic [15:0] e_addr, e_wdata, e_load;
        logic        e_rd, e_wr, e_stall, e_done, e_err;
        logic [1:0]  e_be;
        logic        lit_valid, lit_err;
        logic [15:0] lit_load;
        int          lit_stall;
    } cyc_t;

    cyc_t sched[$];
    cyc_t cur;
    bit   cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   cyc = 0;
    int   stall_cnt = 0;

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.rst_n = 1'b1; c.req = 1'b0; c.rd = 1'b0; c.wr = 1'b0; c.ind = 1'b0;
        c.resp = 1'b0; c.sig = 2'b00; c.addr = 16'h0; c.sd = 16'h0;
        c.rdata = 16'($urandom);
        c.e_addr = 16'h0; c.e_wdata = 16'h0; c.e_load = 16'h0;
        c.e_rd = 1'b0; c.e_wr = 1'b0; c.e_stall = 1'b0; c.e_done = 1'b0; c.e_err = 1'b0;
        c.e_be = 2'b00;
        c.lit_valid = 1'b0; c.lit_err = 1'b0; c.lit_load = 16'h0; c.lit_stall = 0;
        return c;
    endfunction

    task automatic plan_noreq(input logic req, input logic rd, input logic [1:0] sig,
                              input logic resp);
        cyc_t c;
        c = idle_cyc();
        c.req = req; c.rd = rd; c.sig = sig; c.resp = resp;
        sched.push_back(c);
    endtask

    // One wait phase: k is the response delay in cycles, negative means never.
    task automatic push_phase(input cyc_t base, input int k, input logic [15:0] rdat,
                              output bit timed_out);
        cyc_t c;
        timed_out = 1'b1;
        for (int i = 0; i < To; i++) begin
            c = base;
            c.resp  = (i == k);
            c.rdata = c.resp ? rdat : 16'($urandom);
            sched.push_back(c);
            if (c.resp) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic plan_txn(input logic [15:0] addr, input logic [15:0] sd,
                            input logic rd, input logic wr, input logic ind,
                            input logic [1:0] sig, input int pk, input logic [15:0] prdata,
                            input int k, input logic [15:0] rdata,
                            input logic [15:0] lit_load, input logic lit_err,
                            input int lit_stall);
        cyc_t base, c;
        bit to = 1'b0;
        bit word = ind || (sig == 2'b11);
        logic [15:0] eaddr = addr;
        base = idle_cyc();
        base.req = 1'b1; base.rd = rd; base.wr = wr; base.ind = ind; base.sig = sig;
        base.addr = addr; base.sd = sd;
        c = base; c.e_stall = 1'b1;
        sched.push_back(c);
        if (ind) begin
            c = base; c.e_rd = 1'b1; c.e_addr = {addr[15:1], 1'b0}; c.e_be = 2'b11;
            c.e_stall = 1'b1;
            push_phase(c, pk, prdata, to);
            eaddr = prdata;
        end
        if (!to) begin
            c = base; c.e_rd = rd; c.e_wr = !rd; c.e_addr = {eaddr[15:1], 1'b0};
            c.e_be = word ? 2'b11 : (eaddr[0] ? 2'b10 : 2'b01);
            c.e_wdata = rd ? 16'h0 : (word ? sd : {sd[7:0], sd[7:0]});
            c.e_stall = 1'b1;
            push_phase(c, k, rdata, to);
        end
        c = base; c.e_done = 1'b1; c.e_err = to;
        if (to || !rd)     c.e_load = 16'h0;
        else if (word)     c.e_load = rdata;
        else if (eaddr[0]) c.e_load = {8'h00, rdata[15:8]};
        else               c.e_load = {8'h00, rdata[7:0]};
        c.lit_valid = 1'b1; c.lit_load = lit_load; c.lit_err = lit_err; c.lit_stall = lit_stall;
        sched.push_back(c);
        plan_noreq(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_address", mem_address, cur.e_addr);
            chk("mem_read", {15'b0, mem_read}, {15'b0, cur.e_rd});
            chk("mem_write", {15'b0, mem_write}, {15'b0, cur.e_wr});
            chk("mem_byte_enable", {14'b0, mem_byte_enable}, {14'b0, cur.e_be});
            chk("mem_wdata", mem_wdata, cur.e_wdata);
            chk("stall", {15'b0, stall}, {15'b0, cur.e_stall});
            chk("done", {15'b0, done}, {15'b0, cur.e_done});
            chk("load_data", load_data, cur.e_load);
            chk("err", {15'b0, err}, {15'b0, cur.e_err});
            if (cur.lit_valid) begin
                chk("lit_load", load_data, cur.lit_load);
                chk("lit_err", {15'b0, err}, {15'b0, cur.lit_err});
                chk("lit_stall_cycles", 16'(stall_cnt), 16'(cur.lit_stall));
            end
            if (!cur.req) stall_cnt = 0;
            else if (stall) stall_cnt++;
            cyc++;
        end
    end

    initial begin
        cyc_t c;
        reset_n = 1'b0; req_valid = 1'b0; read = 1'b0; write = 1'b0; indirect = 1'b0;
        mem_byte_sig = 2'b00; address = 16'h0; store_data = 16'h0;
        mem_resp = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(posedge clk);

        // Reset state and requests that must not be accepted.
        plan_noreq(1'b0, 1'b0, 2'b00, 1'b0);
        plan_noreq(1'b0, 1'b0, 2'b00, 1'b1);
        plan_noreq(1'b1, 1'b1, 2'b00, 1'b0);
        plan_noreq(1'b0, 1'b1, 2'b11, 1'b1);
        // addr, sd, rd, wr, ind, sig, pk, prdata, k, rdata, lit_load, lit_err, lit_stall
        plan_txn(16'h1235, 16'h0000, 1, 0, 0, 2'b11, 0, 16'h0, 2, 16'hBEEF, 16'hBEEF, 0, 4);
        plan_txn(16'h2001, 16'h00A5, 0, 1, 0, 2'b01, 0, 16'h0, 1, 16'h0,    16'h0000, 0, 3);
        plan_txn(16'h3000, 16'h0000, 1, 0, 0, 2'b01, 0, 16'h0, 0, 16'h7F80, 16'h0080, 0, 2);
        plan_txn(16'h3001, 16'h0000, 1, 0, 0, 2'b01, 0, 16'h0, 0, 16'h7F80, 16'h007F, 0, 2);
        plan_txn(16'h4000, 16'h0000, 1, 0, 1, 2'b11, 0, 16'h5003, 1, 16'h1111, 16'h1111, 0, 4);
        plan_txn(16'h4000, 16'h1234, 0, 1, 1, 2'b01, 1, 16'h5003, 0, 16'h0, 16'h0000, 0, 4);
        plan_txn(16'h6000, 16'h0000, 1, 0, 0, 2'b11, 0, 16'h0, -1, 16'h0, 16'h0000, 1, 5);
        plan_txn(16'h6002, 16'h0000, 1, 0, 0, 2'b11, 0, 16'h0, 3, 16'h2222, 16'h2222, 0, 5);
        plan_txn(16'h7000, 16'hFFFF, 1, 1, 0, 2'b11, 0, 16'h0, 0, 16'h3333, 16'h3333, 0, 2);
        plan_txn(16'h4000, 16'h0000, 1, 0, 1, 2'b11, -1, 16'h0, 0, 16'h0, 16'h0000, 1, 5);

        // Reset while in the pointer phase, then a stray response.
        c = idle_cyc();
        c.req = 1'b1; c.rd = 1'b1; c.ind = 1'b1; c.sig = 2'b11; c.addr = 16'h4000;
        c.e_stall = 1'b1;
        sched.push_back(c);
        c.e_rd = 1'b1; c.e_addr = 16'h4000; c.e_be = 2'b11;
        sched.push_back(c);
        c.rst_n = 1'b0;
        sched.push_back(c);
        plan_noreq(1'b0, 1'b0, 2'b00, 1'b1);
        plan_noreq(1'b0, 1'b0, 2'b00, 1'b0);
        plan_noreq(1'b0, 1'b0, 2'b00, 1'b0);

        foreach (sched[i]) begin
            @(posedge clk);
            #1;
            reset_n      = sched[i].rst_n;
            req_valid    = sched[i].req;
            read         = sched[i].rd;
            write        = sched[i].wr;
            indirect     = sched[i].ind;
            mem_byte_sig = sched[i].sig;
            address      = sched[i].addr;
            store_data   = sched[i].sd;
            mem_resp     = sched[i].resp;
            mem_rdata    = sched[i].rdata;
            cur          = sched[i];
            cmp_en       = 1'b1;
        end
        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
